cgra_data_bus_arbiter: RTL

Shares the CGRA's N_REQ column data-bus request interfaces among N_PORT memory-side master ports, placed between the column data bus handlers and the system bus. Each requester is statically bound to one port, and requesters sharing a port are served round-robin. The block tracks outstanding transactions per port with a tag FIFO so each in-order response returns to the requester that issued it. It uses an OBI-style protocol: the address phase completes on req&gnt, and each accepted transaction, read or write, produces exactly one rvalid.

---
 rtl/cgra_data_bus_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/cgra_data_bus_arbiter.sv
// cgra_data_bus_arbiter
// Shares N_REQ column data-bus requesters among N_PORT OBI-style master ports.
// Requester r is statically bound to port r mod N_PORT; requesters sharing a
// port are served round-robin. Each port keeps a tag FIFO of accepted
// transactions so that in-order responses return to the issuing requester.
//
// Handshake: an address phase completes in the cycle where req and gnt are
// both high. Once a port raises port_req_o without a grant, its winner is held
// (req and address stay stable) until port_gnt_i arrives. Every accepted
// transaction, read or write, returns exactly one port_rvalid_i.
//
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   req_i/we_i/be_i/add_i/wdata_i     per-requester address phase
//   gnt_o                             per-requester grant (combinational)
//   rvalid_o/rdata_o                  per-requester response (rdata 0 when idle)
//   port_req_o/we/be/add/wdata        per-port address phase of the winner
//   port_gnt_i                        per-port grant
//   port_rvalid_i/port_rdata_i        per-port response
//   busy_o                            any port has outstanding transactions
//   err_o                             sticky: response seen with empty FIFO
module cgra_data_bus_arbiter #(
  parameter int N_REQ      = 4,
  parameter int N_PORT     = 2,
  parameter int ADD_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST  = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [N_REQ-1:0]                     req_i,
  input  logic [N_REQ-1:0]                     we_i,
  input  logic [N_REQ-1:0][3:0]                be_i,
  input  logic [N_REQ-1:0][ADD_WIDTH-1:0]      add_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     wdata_i,
  output logic [N_REQ-1:0]                     gnt_o,
  output logic [N_REQ-1:0]                     rvalid_o,
  output logic [N_REQ-1:0][DATA_WIDTH-1:0]     rdata_o,
  output logic [N_PORT-1:0]                    port_req_o,
  output logic [N_PORT-1:0]                    port_we_o,
  output logic [N_PORT-1:0][3:0]               port_be_o,
  output logic [N_PORT-1:0][ADD_WIDTH-1:0]     port_add_o,
  output logic [N_PORT-1:0][DATA_WIDTH-1:0]    port_wdata_o,
  input  logic [N_PORT-1:0]                    port_gnt_i,
  input  logic [N_PORT-1:0]                    port_rvalid_i,
  input  logic [N_PORT-1:0][DATA_WIDTH-1:0]    port_rdata_i,
  output logic                                 busy_o,
  output logic                                 err_o
);

  localparam int G  = N_REQ / N_PORT;                        // group size
  localparam int TW = (G > 1) ? $clog2(G) : 1;               // local index width
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);

  typedef logic [TW-1:0] tag_t;
  typedef enum logic { LK_FREE = 1'b0, LK_HELD = 1'b1 } lock_t;

  // Registered state
  tag_t            prio_q   [N_PORT];
  lock_t           lock_q   [N_PORT];
  tag_t            lock_k_q [N_PORT];
  tag_t            fifo_q   [N_PORT][MAX_OUTST];
  logic [PW-1:0]   wptr_q   [N_PORT];
  logic [PW-1:0]   rptr_q   [N_PORT];
  logic [CW-1:0]   cnt_q    [N_PORT];
  logic            err_q;

  // Combinational per-port decisions
  logic [G-1:0]    grp_req  [N_PORT];
  logic [N_PORT-1:0] win_v, fire, pop, ovf;
  tag_t            win_k    [N_PORT];
  tag_t            head     [N_PORT];

  // Local index visited at step i of a search starting at start.
  function automatic tag_t rr_idx(input tag_t start, input int i);
    rr_idx = tag_t'((int'(start) + i) % G);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == PW'(MAX_OUTST - 1)) ptr_inc = '0;
    else                           ptr_inc = ptr + PW'(1);
  endfunction

  always_comb begin
    port_req_o   = '0;
    port_we_o    = '0;
    port_be_o    = '0;
    port_add_o   = '0;
    port_wdata_o = '0;
    gnt_o        = '0;
    rvalid_o     = '0;
    rdata_o      = '0;
    win_v        = '0;
    fire         = '0;
    pop          = '0;
    ovf          = '0;
    for (int p = 0; p < N_PORT; p++) begin
      for (int k = 0; k < G; k++) grp_req[p][k] = req_i[k*N_PORT+p];
      // A held winner overrides the round-robin search.
      win_v[p] = (lock_q[p] == LK_HELD);
      win_k[p] = lock_k_q[p];
      if (lock_q[p] == LK_FREE) begin
        for (int i = 0; i < G; i++) begin
          if (!win_v[p] && grp_req[p][rr_idx(prio_q[p], i)]) begin
            win_v[p] = 1'b1;
            win_k[p] = rr_idx(prio_q[p], i);
          end
        end
      end
      // Gated by the count before any same-cycle pop.
      port_req_o[p] = win_v[p] && (cnt_q[p] < CW'(MAX_OUTST));
      fire[p]       = port_req_o[p] && port_gnt_i[p];
      pop[p]        = port_rvalid_i[p] && (cnt_q[p] != '0);
      ovf[p]        = port_rvalid_i[p] && (cnt_q[p] == '0);
      head[p]       = fifo_q[p][rptr_q[p]];
      for (int k = 0; k < G; k++) begin
        if (win_v[p] && (win_k[p] == tag_t'(k))) begin
          port_we_o[p]    = we_i[k*N_PORT+p];
          port_be_o[p]    = be_i[k*N_PORT+p];
          port_add_o[p]   = add_i[k*N_PORT+p];
          port_wdata_o[p] = wdata_i[k*N_PORT+p];
        end
      end
    end
    for (int r = 0; r < N_REQ; r++) begin
      gnt_o[r]    = fire[r%N_PORT] && (win_k[r%N_PORT] == tag_t'(r / N_PORT));
      rvalid_o[r] = pop[r%N_PORT]  && (head[r%N_PORT]  == tag_t'(r / N_PORT));
      if (rvalid_o[r]) rdata_o[r] = port_rdata_i[r%N_PORT];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
      for (int p = 0; p < N_PORT; p++) begin
        prio_q[p]   <= '0;
        lock_q[p]   <= LK_FREE;
        lock_k_q[p] <= '0;
        wptr_q[p]   <= '0;
        rptr_q[p]   <= '0;
        cnt_q[p]    <= '0;
        for (int s = 0; s < MAX_OUTST; s++) fifo_q[p][s] <= '0;
      end
    end else begin
      if (|ovf) err_q <= 1'b1;
      for (int p = 0; p < N_PORT; p++) begin
        if (fire[p]) begin
          fifo_q[p][wptr_q[p]] <= win_k[p];
          wptr_q[p]            <= ptr_inc(wptr_q[p]);
          prio_q[p]            <= (win_k[p] == tag_t'(G - 1)) ? '0 : win_k[p] + tag_t'(1);
          lock_q[p]            <= LK_FREE;
        end else if (port_req_o[p]) begin
          lock_q[p]   <= LK_HELD;
          lock_k_q[p] <= win_k[p];
        end
        if (pop[p]) rptr_q[p] <= ptr_inc(rptr_q[p]);
        case ({fire[p], pop[p]})
          2'b10:   cnt_q[p] <= cnt_q[p] + CW'(1);
          2'b01:   cnt_q[p] <= cnt_q[p] - CW'(1);
          default: cnt_q[p] <= cnt_q[p];
        endcase
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int p = 0; p < N_PORT; p++) if (cnt_q[p] != '0) busy_o = 1'b1;
  end

  assign err_o = err_q;

endmodule
